pipeline_memory: RTL

//  Memory stage; sits directly downstream of the execute stage. Consumes execute_done/
//  _is_dependent/_result/_instr, runs loads/stores on a req/ack data-memory port, and

---
 rtl/pipeline_memory.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_memory.sv
// Memory stage: passes ALU results through and runs loads/stores on a req/ack data port.
// Optional WAIT timeout/abort is enabled by defining MEMORY_TIMEOUT_EN.
module pipeline_memory #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              execute_done,
    input  logic              execute_is_dependent,
    input  logic [15:0]       execute_result,
    input  logic [15:0]       execute_instr,
    input  logic [15:0]       store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              stall,
    output logic              mem_error,
    output logic              memory_done,
    output logic              memory_is_dependent,
    output logic [15:0]       memory_result,
    output logic [15:0]       memory_instr
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic logic is_load_op(input logic [15:0] instr);
        return (instr[15:12] == 4'b1000);
    endfunction

    function automatic logic is_store_op(input logic [15:0] instr);
        return (instr[15:12] == 4'b1001);
    endfunction

    state_t              state_r, state_s;
    logic                req_r, req_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [15:0]         wdata_r, wdata_s;
    logic [15:0]         cap_instr_r, cap_instr_s;
    logic                stall_r;
    logic                done_r, done_s;
    logic                dep_r, dep_s;
    logic [15:0]         result_r, result_s;
    logic [15:0]         instr_r, instr_s;
    logic                err_r, err_s;

`ifdef MEMORY_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]    cnt_r, cnt_s;
`endif

    // Next-state, memory-port and stage-output decode.
    always_comb begin
        state_s     = state_r;
        req_s       = req_r;
        we_s        = we_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        cap_instr_s = cap_instr_r;
        err_s       = err_r;
        done_s      = 1'b0;
        dep_s       = 1'b0;
        result_s    = 16'h0000;
        instr_s     = 16'h0000;
`ifdef MEMORY_TIMEOUT_EN
        cnt_s       = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (is_load_op(execute_instr) || is_store_op(execute_instr)) begin
                    state_s     = WAIT;
                    req_s       = 1'b1;
                    we_s        = is_store_op(execute_instr);
                    addr_s      = execute_result[ADDR_W-1:0];
                    wdata_s     = store_data;
                    cap_instr_s = execute_instr;
`ifdef MEMORY_TIMEOUT_EN
                    cnt_s       = '0;
`endif
                end else begin
                    done_s   = execute_done;
                    dep_s    = execute_is_dependent;
                    result_s = execute_result;
                    instr_s  = execute_instr;
                end
            end
            WAIT: begin
                // Ack wins over a simultaneous timeout.
                if (mem_ack) begin
                    state_s  = IDLE;
                    req_s    = 1'b0;
                    done_s   = 1'b1;
                    dep_s    = ~we_r;
                    result_s = we_r ? 16'(addr_r) : mem_rdata;
                    instr_s  = cap_instr_r;
`ifdef MEMORY_TIMEOUT_EN
                end else if (cnt_r == CNT_LAST) begin
                    state_s  = IDLE;
                    req_s    = 1'b0;
                    err_s    = 1'b1;
                    done_s   = 1'b1;
                    dep_s    = 1'b0;
                    result_s = 16'h0000;
                    instr_s  = cap_instr_r;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
`else
                end else begin
                    state_s = WAIT;
                end
`endif
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
`ifndef MEMORY_TIMEOUT_EN
        err_s = 1'b0;
`endif
    end

    // State, memory-port and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 16'h0000;
            cap_instr_r <= 16'h0000;
            stall_r     <= 1'b0;
            err_r       <= 1'b0;
            done_r      <= 1'b0;
            dep_r       <= 1'b0;
            result_r    <= 16'h0000;
            instr_r     <= 16'h0000;
        end else begin
            state_r     <= state_s;
            req_r       <= req_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            cap_instr_r <= cap_instr_s;
            stall_r     <= (state_s == WAIT);
            err_r       <= err_s;
            done_r      <= done_s;
            dep_r       <= dep_s;
            result_r    <= result_s;
            instr_r     <= instr_s;
        end
    end

`ifdef MEMORY_TIMEOUT_EN
    // WAIT-cycle counter for the abort timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end
`endif

    assign mem_req             = req_r;
    assign mem_we              = we_r;
    assign mem_addr            = addr_r;
    assign mem_wdata           = wdata_r;
    assign stall               = stall_r;
    assign mem_error           = err_r;
    assign memory_done         = done_r;
    assign memory_is_dependent = dep_r;
    assign memory_result       = result_r;
    assign memory_instr        = instr_r;

endmodule
